// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Debounces a 4-bit coin sensor bank and turns each qualified coin into a
// strobe for the vending controller.
//
// Accepted coin:  coin_in is high for PULSE_CYC cycles.  coin_value is valid
//                 for the strobe plus GAP_CYC further cycles.
// Rejected coin:  reject is pulsed for one cycle.  This covers a multi-hot
//                 pattern or accept_en low at qualification.
//
// After either outcome the sensors must read zero for DEBOUNCE_CYC cycles
// before the next coin can be qualified.  If they do not release within
// JAM_CYC cycles, the sticky jam flag is raised.  While jam is set, new
// coins are ignored.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   coin_sense  raw async sensors: bit0=1, bit1=2, bit2=5, bit3=10 units
//   accept_en   1 = accept coins, 0 = reject them (sampled at qualification)
//   credit_clr  synchronous clear of credit
//   jam_clr     synchronous clear of jam
//   coin_in     coin strobe
//   coin_value  value of the accepted coin during strobe and gap, else 0
//   reject      one-cycle pulse per rejected coin
//   credit      saturating sum of accepted coin values
//   coin_count  saturating count of accepted coins
//   jam         sticky jam flag
// -----------------------------------------------------------------------------
module coin_acceptor #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int PULSE_CYC    = 2,
    parameter int GAP_CYC      = 2,
    parameter int JAM_CYC      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] coin_sense,
    input  logic       accept_en,
    input  logic       credit_clr,
    input  logic       jam_clr,
    output logic       coin_in,
    output logic [3:0] coin_value,
    output logic       reject,
    output logic [7:0] credit,
    output logic [7:0] coin_count,
    output logic       jam
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] QUALIFY      = 3'd1;
    localparam logic [2:0] PRESENT      = 3'd2;
    localparam logic [2:0] GAP          = 3'd3;
    localparam logic [2:0] WAIT_RELEASE = 3'd4;

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC) + 1);
    localparam int JW = $clog2(JAM_CYC + 1);

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] PULSE_MAX = TW'(PULSE_CYC);
    localparam logic [TW-1:0] GAP_MAX   = TW'(GAP_CYC);
    localparam logic [JW-1:0] JAM_MAX   = JW'(JAM_CYC);
    localparam logic [JW-1:0] JAM_LAST  = JW'(JAM_CYC - 1);

    // Two-flop synchronizer per sensor bit.
    logic [3:0] sync;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_q;
            logic sync_bit_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_q     <= 1'b0;
                    sync_bit_q <= 1'b0;
                end else begin
                    meta_q     <= coin_sense[gi];
                    sync_bit_q <= meta_q;
                end
            end
            assign sync[gi] = sync_bit_q;
        end
    endgenerate

    function automatic logic [3:0] coin_weight(input logic [3:0] pat);
        logic [3:0] w;
        case (pat)
            4'b0001: w = 4'd1;
            4'b0010: w = 4'd2;
            4'b0100: w = 4'd5;
            4'b1000: w = 4'd10;
            default: w = 4'd0;
        endcase
        return w;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;       // stability count (qualify / release)
    logic [3:0]    pat_q, pat_d;         // captured sensor pattern
    logic [TW-1:0] tmr_q, tmr_d;         // strobe / gap length
    logic [JW-1:0] wait_q, wait_d;       // cycles spent waiting for release
    logic          coin_in_q, coin_in_d;
    logic [3:0]    coin_value_q, coin_value_d;
    logic          reject_q, reject_d;
    logic [7:0]    credit_q, credit_d;
    logic [7:0]    coin_count_q, coin_count_d;
    logic          jam_q, jam_d;
    logic [7:0]    credit_base;
    logic [8:0]    credit_sum;

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        pat_d        = pat_q;
        tmr_d        = tmr_q;
        wait_d       = wait_q;
        coin_in_d    = coin_in_q;
        coin_value_d = coin_value_q;
        reject_d     = 1'b0;
        coin_count_d = coin_count_q;
        jam_d        = jam_clr ? 1'b0 : jam_q;
        // Clear first, so a clear coinciding with a new coin leaves that coin.
        credit_base  = credit_clr ? 8'd0 : credit_q;
        credit_sum   = {1'b0, credit_base} + {5'd0, coin_weight(pat_q)};
        credit_d     = credit_base;

        case (state_q)
            IDLE: begin
                if (!jam_q && sync != 4'd0) begin
                    state_d = QUALIFY;
                    pat_d   = sync;
                    dcnt_d  = {{(DW-1){1'b0}}, 1'b1};
                end
            end
            QUALIFY: begin
                if (dcnt_q == DEB_MAX) begin
                    if ($onehot(pat_q) && accept_en) begin
                        state_d      = PRESENT;
                        coin_in_d    = 1'b1;
                        coin_value_d = coin_weight(pat_q);
                        tmr_d        = {{(TW-1){1'b0}}, 1'b1};
                        credit_d     = credit_sum[8] ? 8'hFF : credit_sum[7:0];
                        coin_count_d = (coin_count_q == 8'hFF) ? coin_count_q
                                                               : coin_count_q + 8'd1;
                    end else begin
                        state_d  = WAIT_RELEASE;
                        reject_d = 1'b1;
                        dcnt_d   = '0;
                        wait_d   = '0;
                    end
                end else if (sync == 4'd0) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (sync == pat_q) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    pat_d  = sync;
                    dcnt_d = {{(DW-1){1'b0}}, 1'b1};
                end
            end
            PRESENT: begin
                if (tmr_q == PULSE_MAX) begin
                    state_d   = GAP;
                    coin_in_d = 1'b0;
                    tmr_d     = {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == GAP_MAX) begin
                    state_d      = WAIT_RELEASE;
                    coin_value_d = 4'd0;
                    dcnt_d       = '0;
                    wait_d       = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (sync == 4'd0 && dcnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = (sync == 4'd0) ? dcnt_q + 1'b1 : '0;
                    // The wait counter saturates, so jam is raised once per
                    // stuck episode.  Raising it takes priority over jam_clr.
                    if (wait_q != JAM_MAX) begin
                        wait_d = wait_q + 1'b1;
                    end
                    if (wait_q == JAM_LAST) begin
                        jam_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            pat_q        <= 4'd0;
            tmr_q        <= '0;
            wait_q       <= '0;
            coin_in_q    <= 1'b0;
            coin_value_q <= 4'd0;
            reject_q     <= 1'b0;
            credit_q     <= 8'd0;
            coin_count_q <= 8'd0;
            jam_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            pat_q        <= pat_d;
            tmr_q        <= tmr_d;
            wait_q       <= wait_d;
            coin_in_q    <= coin_in_d;
            coin_value_q <= coin_value_d;
            reject_q     <= reject_d;
            credit_q     <= credit_d;
            coin_count_q <= coin_count_d;
            jam_q        <= jam_d;
        end
    end

    assign coin_in    = coin_in_q;
    assign coin_value = coin_value_q;
    assign reject     = reject_q;
    assign credit     = credit_q;
    assign coin_count = coin_count_q;
    assign jam        = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//
// Drives coin_acceptor with directed scenarios followed by randomized sensor
// traffic.  Every cycle, the outputs are compared against a behavioural
// model that tracks the coin's life in coarse phases.  The strobe and gap
// are modelled as one countdown.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

    localparam int DEB   = 4;
    localparam int PULSE = 2;
    localparam int GAPC  = 2;
    localparam int JAM   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] coin_sense;
    logic       accept_en;
    logic       credit_clr;
    logic       jam_clr;
    logic       coin_in;
    logic [3:0] coin_value;
    logic       reject;
    logic [7:0] credit;
    logic [7:0] coin_count;
    logic       jam;

    coin_acceptor #(
        .DEBOUNCE_CYC (DEB),
        .PULSE_CYC    (PULSE),
        .GAP_CYC      (GAPC),
        .JAM_CYC      (JAM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_sense (coin_sense),
        .accept_en  (accept_en),
        .credit_clr (credit_clr),
        .jam_clr    (jam_clr),
        .coin_in    (coin_in),
        .coin_value (coin_value),
        .reject     (reject),
        .credit     (credit),
        .coin_count (coin_count),
        .jam        (jam)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE   = 0;   // waiting for a coin
    localparam int M_QUAL   = 1;   // watching a pattern settle
    localparam int M_STROBE = 2;   // strobe + gap, countdown in m_left
    localparam int M_WAIT   = 3;   // waiting for the sensors to clear

    int         m_mode;
    logic [3:0] m_s1, m_s2, m_pat;
    int         m_run, m_left, m_zeros, m_waited, m_val;
    int         m_credit, m_count;
    bit         m_reject, m_jam;

    function automatic int value_of(input logic [3:0] p);
        int w[4] = '{1, 2, 5, 10};
        int s = 0;
        for (int b = 0; b < 4; b++) if (p[b]) s += w[b];
        return s;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_pat = 0;
        m_run = 0; m_left = 0; m_zeros = 0; m_waited = 0; m_val = 0;
        m_credit = 0; m_count = 0; m_reject = 0; m_jam = 0;
    endtask

    // One rising edge, seen with the inputs the DUT samples at that edge.
    task automatic model_step();
        logic [3:0] sv;
        bit         set_jam;
        int         base;
        if (!rst_n) begin
            model_reset();
        end else begin
            sv       = m_s2;
            m_s2     = m_s1;
            m_s1     = coin_sense;
            m_reject = 0;
            set_jam  = 0;
            base     = credit_clr ? 0 : m_credit;
            case (m_mode)
                M_IDLE: if (!m_jam && sv != 0) begin
                    m_mode = M_QUAL; m_pat = sv; m_run = 1;
                end
                M_QUAL: begin
                    if (m_run == DEB) begin
                        if ($countones(m_pat) == 1 && accept_en) begin
                            m_mode  = M_STROBE;
                            m_left  = PULSE + GAPC;
                            m_val   = value_of(m_pat);
                            base    = sat255(base + m_val);
                            m_count = sat255(m_count + 1);
                            $display("[%0t] coin accepted value=%0d credit=%0d count=%0d",
                                     $time, m_val, base, m_count);
                        end else begin
                            m_reject = 1; m_mode = M_WAIT; m_zeros = 0; m_waited = 0;
                            $display("[%0t] coin rejected pattern=%b accept_en=%0b",
                                     $time, m_pat, accept_en);
                        end
                    end else if (sv == 0) m_mode = M_IDLE;
                    else if (sv == m_pat) m_run++;
                    else begin m_pat = sv; m_run = 1; end
                end
                M_STROBE: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_WAIT; m_zeros = 0; m_waited = 0; end
                end
                default: begin
                    m_zeros = (sv == 0) ? m_zeros + 1 : 0;
                    if (m_zeros == DEB) m_mode = M_IDLE;
                    else begin
                        m_waited++;
                        if (m_waited == JAM) set_jam = 1;
                    end
                end
            endcase
            m_credit = base;
            m_jam    = set_jam ? 1'b1 : (jam_clr ? 1'b0 : m_jam);
        end
    endtask

    // Advance one clock and compare all outputs with the model.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_eq("coin_in",    coin_in,    (m_mode == M_STROBE && m_left > GAPC) ? 1 : 0);
        check_eq("coin_value", coin_value, (m_mode == M_STROBE) ? m_val : 0);
        check_eq("reject",     reject,     m_reject);
        check_eq("credit",     credit,     m_credit);
        check_eq("coin_count", coin_count, m_count);
        check_eq("jam",        jam,        m_jam);
    endtask

    int rej_seen, strobe_seen;

    initial begin
        model_reset();
        rst_n = 0; coin_sense = 0; accept_en = 0; credit_clr = 0; jam_clr = 0;
        repeat (3) cyc();
        check_eq("rst_credit", credit, 0);
        check_eq("rst_count", coin_count, 0);
        check_eq("rst_coin_in", coin_in, 0);
        rst_n = 1; accept_en = 1;
        repeat (2) cyc();

        // Single 5-unit coin: strobe timing and value window.
        coin_sense = 4'b0100;
        repeat (6) cyc();
        check_eq("lat_pre", coin_in, 0);
        cyc();
        check_eq("lat_rise", coin_in, 1);
        check_eq("lat_val", coin_value, 5);
        cyc();
        check_eq("pulse_2", coin_in, 1);
        cyc();
        check_eq("pulse_end", coin_in, 0);
        check_eq("gap_val", coin_value, 5);
        repeat (2) cyc();
        check_eq("gap_end_val", coin_value, 0);
        repeat (9) cyc();
        coin_sense = 0;
        repeat (10) cyc();
        check_eq("c5_credit", credit, 5);
        check_eq("c5_count", coin_count, 1);

        // Multi-hot pattern: one reject, no strobe.
        coin_sense = 4'b0011; rej_seen = 0; strobe_seen = 0;
        repeat (16) begin cyc(); rej_seen += int'(reject); strobe_seen += int'(coin_in); end
        coin_sense = 0;
        repeat (10) begin cyc(); rej_seen += int'(reject); strobe_seen += int'(coin_in); end
        check_eq("mh_rejects", rej_seen, 1);
        check_eq("mh_strobes", strobe_seen, 0);
        check_eq("mh_credit", credit, 5);

        // Short glitch: nothing happens.
        coin_sense = 4'b0001; rej_seen = 0; strobe_seen = 0;
        repeat (3) begin cyc(); rej_seen += int'(reject); strobe_seen += int'(coin_in); end
        coin_sense = 0;
        repeat (10) begin cyc(); rej_seen += int'(reject); strobe_seen += int'(coin_in); end
        check_eq("gl_rejects", rej_seen, 0);
        check_eq("gl_strobes", strobe_seen, 0);

        // Credit saturation with 26 tens, then clear coinciding with coin 27.
        rst_n = 0; cyc(); rst_n = 1;
        repeat (26) begin
            coin_sense = 4'b1000; repeat (12) cyc();
            coin_sense = 0;       repeat (8) cyc();
        end
        check_eq("sat_credit", credit, 255);
        check_eq("sat_count", coin_count, 26);
        coin_sense = 4'b1000;
        repeat (6) cyc();
        credit_clr = 1; cyc(); credit_clr = 0;
        check_eq("clr_add_credit", credit, 10);
        check_eq("clr_add_count", coin_count, 27);
        repeat (5) cyc();
        coin_sense = 0; repeat (8) cyc();

        // Stuck sensor: jam, coins ignored until jam_clr.
        coin_sense = 4'b1000; repeat (100) cyc();
        check_eq("jam_set", jam, 1);
        check_eq("jam_count", coin_count, 28);
        coin_sense = 0; repeat (8) cyc();
        coin_sense = 4'b0001; repeat (15) cyc();
        check_eq("jam_ignored", coin_count, 28);
        jam_clr = 1; cyc(); jam_clr = 0;
        check_eq("jam_cleared", jam, 0);
        repeat (12) cyc();
        check_eq("after_jam_count", coin_count, 29);
        coin_sense = 0; repeat (10) cyc();

        // Reset during the strobe; held coin is taken again after release.
        coin_sense = 4'b0010; repeat (7) cyc();
        check_eq("rst_pre_strobe", coin_in, 1);
        rst_n = 0; cyc();
        check_eq("rst_abort_coin_in", coin_in, 0);
        check_eq("rst_abort_credit", credit, 0);
        rst_n = 1; repeat (12) cyc();
        check_eq("reaccept_count", coin_count, 1);
        check_eq("reaccept_credit", credit, 2);
        coin_sense = 0; repeat (10) cyc();

        // Randomized traffic.
        for (int seg = 0; seg < 300; seg++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 3)      coin_sense = 4'b0000;
            else if (r < 8) coin_sense = 4'(1 << $urandom_range(0, 3));
            else            coin_sense = 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(70, 90) : $urandom_range(1, 12);
            accept_en = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < len; k++) begin
                credit_clr = ($urandom_range(0, 15) == 0);
                jam_clr    = ($urandom_range(0, 31) == 0);
                rst_n      = ($urandom_range(0, 199) != 0);
                cyc();
            end
        end
        rst_n = 1; credit_clr = 0; jam_clr = 0; coin_sense = 0;
        repeat (10) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive stable cycles required to qualify a sensor pattern.
REQ-002 Parameter PULSE_CYC, default 2: cycles coin_in is held high per accepted coin.
REQ-003 Parameter GAP_CYC, default 2: cycles coin_value is held after coin_in falls.
REQ-004 Parameter JAM_CYC, default 64: maximum WAIT_RELEASE cycles before jam is flagged.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 coin_sense  input  4  raw asynchronous coin sensors; bit0=1, bit1=2, bit2=5, bit3=10 units.
REQ-008 accept_en  input  1  high = coins accepted; low = coins rejected.
REQ-009 credit_clr  input  1  synchronous clear of credit.
REQ-010 jam_clr  input  1  synchronous clear of jam.
REQ-011 coin_in  output  1  coin strobe to the vending controller; the controller advances on its rising edge.
REQ-012 coin_value  output  4  value of the accepted coin, stable for the whole strobe and gap.
REQ-013 reject  output  1  one-cycle pulse per rejected coin.
REQ-014 credit  output  8  saturating sum of accepted coin values.
REQ-015 coin_count  output  8  saturating count of accepted coins.
REQ-016 jam  output  1  sticky jam flag.

Function
REQ-017 coin_sense SHALL pass through a 2-flop synchronizer per bit; all further logic SHALL use the synchronized value (sync).
REQ-018 FSM states SHALL be IDLE, QUALIFY, PRESENT, GAP, WAIT_RELEASE.
REQ-019 IDLE: sync nonzero -> QUALIFY with stability counter = 1 and the pattern captured.
REQ-020 QUALIFY: sync equals the captured pattern -> counter increments; sync changes to another nonzero pattern -> recapture, counter = 1; sync zero -> IDLE, no event.
REQ-021 Counter reaching DEBOUNCE_CYC with a one-hot pattern and accept_en high -> PRESENT; coin_value = decoded value; coin_in = 1 on the same edge.
REQ-022 Counter reaching DEBOUNCE_CYC with a multi-hot pattern, or accept_en low -> reject = 1 for one cycle; -> WAIT_RELEASE; coin_in stays 0 and coin_value stays 0.
REQ-023 PRESENT: coin_in high for exactly PULSE_CYC cycles, then -> GAP with coin_in = 0.
REQ-024 GAP: coin_value held for exactly GAP_CYC cycles, then -> WAIT_RELEASE.
REQ-025 coin_value SHALL be 0 in all states except PRESENT and GAP.
REQ-026 WAIT_RELEASE: sync zero for DEBOUNCE_CYC consecutive cycles -> IDLE; any nonzero sync SHALL restart that count.
REQ-027 WAIT_RELEASE lasting JAM_CYC cycles without release SHALL set jam; the FSM SHALL stay in WAIT_RELEASE.
REQ-028 jam SHALL be cleared only by jam_clr or reset; jam_clr in the cycle jam would set -> set wins.
REQ-029 While jam = 1, IDLE SHALL NOT leave IDLE; sensors SHALL be ignored.
REQ-030 On entry to PRESENT: credit += coin_value, saturating at 255; coin_count += 1, saturating at 255.
REQ-031 credit_clr in the same cycle as a PRESENT entry -> credit = coin_value (clear, then add).
REQ-032 credit_clr in any other cycle -> credit = 0; coin_count SHALL be unaffected.
REQ-033 accept_en SHALL be sampled only at qualification; changes during PRESENT or GAP SHALL NOT truncate the strobe.
REQ-034 Latency: coin_in SHALL rise DEBOUNCE_CYC + 2 cycles after the first edge that samples a stable one-hot coin_sense.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 rst_n = 0 at a clk edge SHALL force: state IDLE; coin_in = 0; coin_value = 0; reject = 0; credit = 0; coin_count = 0; jam = 0; synchronizers and counters = 0.
REQ-037 Reset during PRESENT or GAP SHALL abort the strobe immediately; credit already added SHALL be cleared by the reset.
REQ-038 A sensor still high after reset release SHALL be treated as a new coin.

Verification (DEBOUNCE_CYC=4, PULSE_CYC=2, GAP_CYC=2, JAM_CYC=64)
REQ-039 coin_sense = 4'b0100 for 20 cycles, accept_en = 1 -> coin_in high 2 cycles starting 6 cycles after first sample; coin_value = 5 for 4 cycles; credit = 5; coin_count = 1.
REQ-040 coin_sense = 4'b0011 held, accept_en = 1 -> single reject pulse; coin_in = 0 throughout; credit unchanged.
REQ-041 coin_sense = 4'b0001 for 3 cycles only -> no coin_in, no reject, return to IDLE.
REQ-042 26 coins of 10 -> credit saturates at 255, coin_count = 26; credit_clr pulsed during the 27th coin's PRESENT entry -> credit = 10.
REQ-043 coin_sense = 4'b1000 held 100 cycles -> one accepted coin; jam = 1 after 64 WAIT_RELEASE cycles; a second coin is ignored until jam_clr.
REQ-044 rst_n low during PRESENT -> coin_in = 0 and credit = 0 next edge; sensor held through reset -> accepted again after release.
